// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants, channel state type and half-period saturation.
// Revision : 1.0
// ============================================================================
package clk_div_pkg;

  localparam int CNT_W        = 20;
  localparam int DEFAULT_HALF = 10230;  // 1.023 MHz -> 50 Hz
  localparam int HALF_1KHZ    = 512;    // approximate code-epoch rate

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // A programmed half-period of 0 behaves as 1.
  function automatic logic [31:0] sat_half(input logic [31:0] h);
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank_if
// Brief    : Control and output bundle of the divider bank.
// Revision : 1.0
// ============================================================================
interface clk_div_bank_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 20
);
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] half_period;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;

  modport master (
    output ch_en, half_period, sync,
    input  clk_out, tick
  );

  modport slave (
    input  ch_en, half_period, sync,
    output clk_out, tick
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ch
// Brief    : One divider channel; new half-periods are latched only at phase
//            boundaries so no runt phases are produced.
// Revision : 1.0
// ============================================================================
module clk_div_ch #(
  parameter int CNT_W        = 20,
  parameter int DEFAULT_HALF = 10230
) (
  input  wire logic             clk_in,
  input  wire logic             rst,
  input  wire logic             ch_en,
  input  wire logic [CNT_W-1:0] half_period,
  input  wire logic             sync,
  output logic                  clk_out,
  output logic                  tick
);
  import clk_div_pkg::*;

  localparam logic [CNT_W-1:0] C_HP_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  ch_state_e        w_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hp_q;
  logic             r_clk;
  logic             r_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hp_nxt;
  logic [CNT_W-1:0] w_hp_in;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic             w_terminal;

  assign w_hp_in    = CNT_W'(sat_half(32'(half_period)));
  assign w_terminal = (r_cnt == (r_hp_q - C_ONE));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_hp_q <= C_HP_RST;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hp_q <= w_hp_nxt;
      r_clk  <= w_clk_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state    = ch_en ? CH_RUN : CH_IDLE;
    w_cnt_nxt  = '0;
    w_hp_nxt   = w_hp_in;
    w_clk_nxt  = 1'b0;
    w_tick_nxt = 1'b0;
    case (w_state)
      CH_IDLE: begin
        // Defaults already hold the channel at phase 0 and track the input.
      end
      CH_RUN: begin
        if (sync) begin
          // Sync outranks a coincident terminal count: no toggle, no tick.
        end else if (w_terminal) begin
          w_clk_nxt  = ~r_clk;
          w_tick_nxt = ~r_clk;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
          w_hp_nxt  = r_hp_q;
          w_clk_nxt = r_clk;
        end
      end
      default: begin
      end
    endcase
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : NUM_CH independent programmable dividers sharing one sync strobe.
// Revision : 1.0
// ============================================================================
module clk_div_bank #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = clk_div_pkg::CNT_W,
  parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input  wire logic      clk_in,
  input  wire logic      rst,
  clk_div_bank_if.slave  bus
);
  import clk_div_pkg::*;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (bus.ch_en[i]),
        .half_period (bus.half_period[i*CNT_W +: CNT_W]),
        .sync        (bus.sync),
        .clk_out     (bus.clk_out[i]),
        .tick        (bus.tick[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Directed and randomized checks of clk_div_bank against an
//            edge-schedule reference model.
// Revision : 1.0
// ============================================================================
module tb_clk_div_bank;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 20;
  localparam int DEFAULT_HALF = 10230;

  logic clk_in = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference: each channel holds the absolute edge number of its next toggle.
  longint            m_edge;
  longint            m_nxt [NUM_CH];
  logic [NUM_CH-1:0] m_lvl;
  logic [NUM_CH-1:0] m_tk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_edge);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_lvl  = '0;
    m_tk   = '0;
    for (int c = 0; c < NUM_CH; c++) m_nxt[c] = DEFAULT_HALF;
  endtask

  task automatic model_edge();
    longint h;
    m_edge++;
    for (int c = 0; c < NUM_CH; c++) begin
      h = longint'(bus.half_period[c*CNT_W +: CNT_W]);
      if (h == 0) h = 1;
      if (!bus.ch_en[c] || bus.sync) begin
        m_lvl[c] = 1'b0;
        m_tk[c]  = 1'b0;
        m_nxt[c] = m_edge + h;
      end else if (m_edge == m_nxt[c]) begin
        m_lvl[c] = ~m_lvl[c];
        m_tk[c]  = m_lvl[c];
        m_nxt[c] = m_edge + h;
      end else begin
        m_tk[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    chk("outs", longint'({bus.clk_out, bus.tick}), longint'({m_lvl, m_tk}));
  endtask

  task automatic set_h(input int c, input logic [CNT_W-1:0] v);
    bus.half_period[c*CNT_W +: CNT_W] = v;
  endtask

  task automatic wait_tick(input int c, input int budget, output longint at);
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.tick[c]) begin
        at = m_edge;
        return;
      end
    end
    chk("tick_timeout", longint'(bus.tick[c]), 1);
    at = m_edge;
  endtask

  task automatic wait_fall(input int c, input int budget, output longint at);
    for (int k = 0; k < budget; k++) begin
      step();
      if (!bus.clk_out[c]) begin
        at = m_edge;
        return;
      end
    end
    chk("fall_timeout", longint'(bus.clk_out[c]), 0);
    at = m_edge;
  endtask

  initial begin
    longint r, r2, f, d, s, t0, t1;
    int     cnt;

    rst             = 1'b1;
    bus.ch_en       = 2'b01;
    bus.sync        = 1'b0;
    bus.half_period = '0;
    set_h(0, CNT_W'(10230));
    set_h(1, CNT_W'(7));
    #2 rst = 1'b0;
    #1 chk("reset_outs", longint'({bus.clk_out, bus.tick}), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    model_reset();

    // 50 Hz channel from reset
    wait_tick(0, 11000, r);
    chk("first_rise", r, 10230);
    wait_tick(0, 21000, r2);
    chk("period", r2 - r, 20460);
    chk("ch1_idle", longint'(bus.clk_out[1]), 0);

    // ratio change in the middle of a high phase
    bus.ch_en[0] = 1'b0;
    set_h(0, CNT_W'(4));
    step();
    bus.ch_en[0] = 1'b1;
    wait_tick(0, 20, r);
    step();
    set_h(0, CNT_W'(2));
    wait_fall(0, 20, f);
    chk("old_half", f - r, 4);
    wait_tick(0, 20, r2);
    chk("new_half", r2 - f, 2);

    // shared sync across different ratios
    bus.ch_en = 2'b11;
    set_h(0, CNT_W'(3));
    set_h(1, CNT_W'(5));
    for (int k = 0; k < 13; k++) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    s = m_edge;
    chk("sync_clr", longint'(bus.clk_out), 0);
    t0 = -1;
    t1 = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.tick[0] && t0 < 0) t0 = m_edge;
      if (bus.tick[1] && t1 < 0) t1 = m_edge;
    end
    chk("sync_rise0", t0 - s, 3);
    chk("sync_rise1", t1 - s, 5);

    // H = 0 and H = 1 both divide by two
    for (int h = 0; h < 2; h++) begin
      bus.ch_en[0] = 1'b0;
      set_h(0, CNT_W'(h));
      step();
      bus.ch_en[0] = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        cnt += int'(bus.tick[0]);
      end
      chk("fast_ticks", cnt, 4);
    end

    // enable drop truncates the high phase, re-enable restarts at phase 0
    bus.ch_en[0] = 1'b0;
    set_h(0, CNT_W'(6));
    step();
    bus.ch_en[0] = 1'b1;
    wait_tick(0, 20, r);
    step();
    step();
    bus.ch_en[0] = 1'b0;
    step();
    chk("drop_en", longint'(bus.clk_out[0]), 0);
    d = m_edge;
    bus.ch_en[0] = 1'b1;
    wait_tick(0, 20, r);
    chk("reen_rise", r - d, 6);

    // asynchronous reset between edges
    step();
    step();
    #2 rst = 1'b0;
    #1 chk("async_rst", longint'({bus.clk_out, bus.tick}), 0);
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    model_reset();

    // sync coincident with a terminal count
    bus.ch_en[0] = 1'b0;
    set_h(0, CNT_W'(3));
    step();
    d = m_edge;
    bus.ch_en[0] = 1'b1;
    step();
    step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    s = m_edge;
    chk("sync_term_edge", s - d, 3);
    chk("sync_term_clk", longint'(bus.clk_out[0]), 0);
    chk("sync_term_tick", longint'(bus.tick[0]), 0);
    wait_tick(0, 10, r);
    chk("sync_term_rise", r - s, 3);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(7) == 0) set_h(c, CNT_W'($urandom_range(9)));
        if ($urandom_range(39) == 0) bus.ch_en[c] = ~bus.ch_en[c];
      end
      bus.sync = ($urandom_range(49) == 0);
      step();
    end
    bus.sync = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
